// File: rtl/ticket_lock_arbiter.sv
// Hardware ticket lock: first-come-first-served mutual exclusion for HIPROC+1 requesters.
// A single dispenser hands out one ticket per cycle. A "now serving" counter admits
// the matching ticket holder only after the previous owner has fully left, which
// leaves one idle cycle between owners.
module ticket_lock_arbiter #(
  parameter int unsigned HIPROC = 3,
  parameter int unsigned SELMSB = 1,
  parameter int unsigned TKMSB  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [HIPROC:0]   req,
  input  logic [HIPROC:0]   rel,
  output logic [HIPROC:0]   grant,
  output logic              busy,
  output logic [SELMSB:0]   owner,
  output logic [TKMSB:0]    qlen
);

  localparam int unsigned NREQ = HIPROC + 1;
  localparam int unsigned SELW = SELMSB + 1;
  localparam int unsigned TKW  = TKMSB + 1;

  // Tickets must stay unique while every requester holds one at the same time.
  if ((64'd1 << TKW) < 64'(NREQ)) begin : g_bad_tkmsb
    $error("ticket_lock_arbiter: 2**(TKMSB+1) must be at least HIPROC+1");
  end

  // Index-valued outputs must be able to name the highest requester.
  if ((64'd1 << SELW) <= 64'(HIPROC)) begin : g_bad_selmsb
    $error("ticket_lock_arbiter: SELMSB too small to represent HIPROC");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CS   = 2'd2
  } rq_state_t;

  rq_state_t         state  [NREQ];
  logic [TKMSB:0]    ticket [NREQ];
  logic [TKMSB:0]    next_ticket;
  logic [TKMSB:0]    now_serving;

  logic [HIPROC:0]   draw;
  logic [HIPROC:0]   admit;
  logic [HIPROC:0]   leave;
  logic              cs_any;
  logic [HIPROC:0]   grant_n;
  logic [SELMSB:0]   owner_n;
  logic [TKMSB:0]    next_ticket_n;
  logic [TKMSB:0]    now_serving_n;

  // Dispenser: the lowest-index idle requester with req set draws this cycle.
  always_comb begin
    logic found;
    draw  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && state[i] == ST_IDLE && req[i]) begin
        draw[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  // Admission is blocked by any current owner, including one leaving on this edge.
  always_comb begin
    cs_any = 1'b0;
    admit  = '0;
    leave  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (state[i] == ST_CS) begin
        cs_any = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      leave[i] = (state[i] == ST_CS) && rel[i];
      admit[i] = (state[i] == ST_WAIT) && (ticket[i] == now_serving) && !cs_any;
    end
  end

  // Next values of the registered outputs and the two ticket counters.
  always_comb begin
    grant_n = '0;
    owner_n = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant_n[i] = admit[i] || ((state[i] == ST_CS) && !rel[i]);
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_n[i]) begin
        owner_n = SELW'(i);
      end
    end
    next_ticket_n = next_ticket + TKW'(|draw);
    now_serving_n = now_serving + TKW'(|leave);
  end

  // Per-requester FSMs, ticket counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        state[i]  <= ST_IDLE;
        ticket[i] <= '0;
      end
      next_ticket <= '0;
      now_serving <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      owner       <= '0;
      qlen        <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        case (state[i])
          ST_IDLE: begin
            if (draw[i]) begin
              state[i]  <= ST_WAIT;
              ticket[i] <= next_ticket;
            end
          end
          ST_WAIT: begin
            if (admit[i]) begin
              state[i] <= ST_CS;
            end
          end
          ST_CS: begin
            if (rel[i]) begin
              state[i] <= ST_IDLE;
            end
          end
          default: state[i] <= ST_IDLE;
        endcase
      end
      next_ticket <= next_ticket_n;
      now_serving <= now_serving_n;
      grant       <= grant_n;
      busy        <= |grant_n;
      owner       <= owner_n;
      qlen        <= next_ticket_n - now_serving_n;
    end
  end

endmodule

// File: tb/tb_ticket_lock_arbiter.sv
// Directed bench for ticket_lock_arbiter with a grant-order scoreboard.
module tb_ticket_lock_arbiter;

  localparam int unsigned HIPROC = 3;
  localparam int unsigned SELMSB = 1;
  localparam int unsigned TKMSB  = 1;
  localparam int unsigned NREQ   = HIPROC + 1;
  localparam int unsigned SELW   = SELMSB + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [HIPROC:0]   req;
  logic [HIPROC:0]   rel;
  logic [HIPROC:0]   grant;
  logic              busy;
  logic [SELMSB:0]   owner;
  logic [TKMSB:0]    qlen;

  int total  = 0;
  int passed = 0;
  int sb[$];
  logic [HIPROC:0] prev_g = '0;

  ticket_lock_arbiter #(
    .HIPROC(HIPROC),
    .SELMSB(SELMSB),
    .TKMSB (TKMSB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req  (req),
    .rel  (rel),
    .grant(grant),
    .busy (busy),
    .owner(owner),
    .qlen (qlen)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Each owner releases one cycle after it sees its grant; requests drop once granted.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || grant != '0) && n < budget) begin
      rel = grant;
      req = req & ~grant;
      step(1);
      n++;
    end
    rel = '0;
    chk("drain_pending", 32'(sb.size()), 32'd0);
    chk("drain_grant", 32'(grant), 32'd0);
    chk("drain_qlen", 32'(qlen), 32'd0);
  endtask

  // Invariants every cycle, plus grant-order scoreboard on each new owner.
  always @(negedge clock) begin
    logic [SELMSB:0] eo;
    int e;
    if (reset === 1'b0) begin
      eo = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (grant[i]) eo = SELW'(i);
      end
      chk("onehot", 32'($onehot0(grant)), 32'd1);
      chk("busy_or", 32'(busy), 32'(|grant));
      chk("owner_match", 32'(owner), 32'(eo));
      if (grant != '0 && grant != prev_g) begin
        chk("idle_gap", 32'(prev_g), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("grant_order", 32'(grant), 32'd1 << e);
        end
      end
    end
    prev_g = grant;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit expired, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    int rise[$];
    logic [HIPROC:0] pg;

    // Reset state
    reset = 1'b1;
    req   = '0;
    rel   = '0;
    step(2);
    reset = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_qlen", 32'(qlen), 32'd0);

    // Single requester: two-cycle grant latency, then release
    req = 4'b0001;
    sb.push_back(0);
    step(1);
    chk("t1_draw_grant", 32'(grant), 32'd0);
    chk("t1_draw_qlen", 32'(qlen), 32'd1);
    step(1);
    chk("t1_grant", 32'(grant), 32'b0001);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_owner", 32'(owner), 32'd0);
    chk("t1_qlen", 32'(qlen), 32'd1);
    req = '0;
    rel = 4'b0001;
    step(1);
    rel = '0;
    chk("t1_rel_grant", 32'(grant), 32'd0);
    chk("t1_rel_busy", 32'(busy), 32'd0);
    chk("t1_rel_qlen", 32'(qlen), 32'd0);

    // All four at once: grants 0,1,2,3 each two cycles apart
    req = 4'b1111;
    for (int i = 0; i < 4; i++) sb.push_back(i);
    pg = '0;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      if (grant != '0 && pg == '0) rise.push_back(c);
      pg  = grant;
      rel = grant;
      req = req & ~grant;
    end
    rel = '0;
    req = '0;
    chk("t2_rise_count", 32'(rise.size()), 32'd4);
    for (int j = 0; j < rise.size() && j < 4; j++) begin
      chk("t2_rise_cycle", 32'(rise[j]), 32'(2 * (j + 1)));
    end
    chk("t2_end_grant", 32'(grant), 32'd0);
    chk("t2_end_qlen", 32'(qlen), 32'd0);

    // Three full rounds with a 2-bit ticket: queue wraps to qlen 0 when four are outstanding
    for (int r = 0; r < 3; r++) begin
      req = 4'b1111;
      for (int i = 0; i < 4; i++) sb.push_back(i);
      for (int k = 1; k <= 4; k++) begin
        step(1);
        chk("t3_qlen", 32'(qlen), 32'(k % 4));
      end
      req = '0;
      chk("t3_holder", 32'(grant), 32'b0001);
      drain(40);
    end

    // Release by owner 2 coincides with a draw by requester 1
    req = 4'b0100;
    sb.push_back(2);
    step(1);
    req = 4'b0001;
    sb.push_back(0);
    step(1);
    req = '0;
    chk("t4_owner2", 32'(grant), 32'b0100);
    rel = 4'b0100;
    req = 4'b0010;
    sb.push_back(1);
    step(1);
    rel = '0;
    req = '0;
    chk("t4_handoff_idle", 32'(grant), 32'd0);
    chk("t4_handoff_qlen", 32'(qlen), 32'd2);
    step(1);
    chk("t4_grant0", 32'(grant), 32'b0001);
    chk("t4_owner0", 32'(owner), 32'd0);
    rel = 4'b0001;
    step(1);
    rel = '0;
    step(1);
    chk("t4_grant1", 32'(grant), 32'b0010);
    chk("t4_qlen1", 32'(qlen), 32'd1);
    drain(40);

    // Release pulse with nothing granted has no effect
    rel = 4'b1111;
    step(1);
    rel = '0;
    chk("t6_rel_grant", 32'(grant), 32'd0);
    chk("t6_rel_qlen", 32'(qlen), 32'd0);
    req = 4'b0100;
    sb.push_back(2);
    step(1);
    req = '0;
    chk("t6_draw_grant", 32'(grant), 32'd0);
    chk("t6_draw_qlen", 32'(qlen), 32'd1);
    step(1);
    chk("t6_grant", 32'(grant), 32'b0100);
    chk("t6_owner", 32'(owner), 32'd2);
    drain(40);

    // Reset mid-operation discards owner and waiting tickets
    req = 4'b0010;
    sb.push_back(1);
    step(1);
    req = 4'b1001;
    sb.push_back(0);
    sb.push_back(3);
    step(2);
    req = '0;
    chk("t5_pre_grant", 32'(grant), 32'b0010);
    chk("t5_pre_qlen", 32'(qlen), 32'd3);
    reset = 1'b1;
    sb.delete();
    step(1);
    reset = 1'b0;
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_owner", 32'(owner), 32'd0);
    chk("t5_rst_qlen", 32'(qlen), 32'd0);
    step(2);
    chk("t5_stay_idle", 32'(grant), 32'd0);
    chk("t5_stay_qlen", 32'(qlen), 32'd0);
    req = 4'b1000;
    sb.push_back(3);
    step(2);
    req = '0;
    chk("t5_grant3", 32'(grant), 32'b1000);
    chk("t5_owner3", 32'(owner), 32'd3);
    drain(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
